// File: rtl/alu_issue.sv
// Sequential front end for the combinational ALU: an operand stack driven by
// push/pop/op/clear commands, issuing stack operands to the ALU and pushing its result.
module alu_issue #(
  parameter int WIDTH_MAG = 5,
  parameter int DEPTH_MAG = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_kind,
  input  logic [3:0]                  cmd_opcode,
  input  logic [(1<<WIDTH_MAG)-1:0]   cmd_data,
  input  logic                        cmd_use_carry,
  output logic [(1<<WIDTH_MAG)-1:0]   alu_a,
  output logic [(1<<WIDTH_MAG)-1:0]   alu_b,
  output logic                        alu_ic,
  output logic [3:0]                  alu_opcode,
  input  logic [(1<<WIDTH_MAG)-1:0]   alu_out,
  input  logic                        alu_oc,
  input  logic                        alu_oo,
  output logic [(1<<WIDTH_MAG)-1:0]   top,
  output logic [DEPTH_MAG:0]          depth,
  output logic                        carry,
  output logic                        overflow,
  output logic                        err_underflow,
  output logic                        err_overflow
);
  localparam int WIDTH = 1 << WIDTH_MAG;
  localparam int DEPTH = 1 << DEPTH_MAG;

  localparam logic [3:0] OP_ADD = 4'h0;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_OP   = 2'd2;
  localparam logic [1:0] K_CLR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        stack_q [DEPTH];
  logic [DEPTH_MAG:0]      depth_q;
  logic [WIDTH-1:0]        alu_a_q, alu_b_q;
  logic                    alu_ic_q;
  logic [3:0]              alu_opcode_q;
  logic                    carry_q, overflow_q, err_uf_q, err_of_q;

  logic                    accept, full, empty, has_two;
  logic [DEPTH_MAG-1:0]    idx_top, idx_sec;

  // Low index bits wrap modulo DEPTH, so depth == DEPTH still selects the last entry.
  assign idx_top = depth_q[DEPTH_MAG-1:0] - DEPTH_MAG'(1);
  assign idx_sec = depth_q[DEPTH_MAG-1:0] - DEPTH_MAG'(2);
  assign full    = (depth_q == (DEPTH_MAG+1)'(DEPTH));
  assign empty   = (depth_q == '0);
  assign has_two = (depth_q >= (DEPTH_MAG+1)'(2));

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      depth_q      <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ic_q     <= 1'b0;
      alu_opcode_q <= 4'h0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
      err_uf_q     <= 1'b0;
      err_of_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (cmd_kind)
              K_PUSH: begin
                if (!full) begin
                  stack_q[depth_q[DEPTH_MAG-1:0]] <= cmd_data;
                  depth_q <= depth_q + (DEPTH_MAG+1)'(1);
                end else begin
                  err_of_q <= 1'b1;
                end
              end
              K_POP: begin
                if (!empty) depth_q <= depth_q - (DEPTH_MAG+1)'(1);
                else        err_uf_q <= 1'b1;
              end
              K_OP: begin
                if (has_two) begin
                  alu_a_q      <= stack_q[idx_sec];
                  alu_b_q      <= stack_q[idx_top];
                  alu_opcode_q <= cmd_opcode;
                  alu_ic_q     <= cmd_use_carry & carry_q;
                  state_q      <= EXEC;
                end else begin
                  err_uf_q <= 1'b1;
                end
              end
              K_CLR: begin
                err_uf_q <= 1'b0;
                err_of_q <= 1'b0;
              end
            endcase
          end
        end
        EXEC: begin
          // Only ADD defines oc/oo; other opcodes leave them undefined.
          stack_q[idx_sec] <= alu_out;
          depth_q          <= depth_q - (DEPTH_MAG+1)'(1);
          if (alu_opcode_q == OP_ADD) begin
            carry_q    <= alu_oc;
            overflow_q <= alu_oo;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ic        = alu_ic_q;
  assign alu_opcode    = alu_opcode_q;
  assign top           = empty ? '0 : stack_q[idx_top];
  assign depth         = depth_q;
  assign carry         = carry_q;
  assign overflow      = overflow_q;
  assign err_underflow = err_uf_q;
  assign err_overflow  = err_of_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a table of command/expectation records plus
// hand-written sequences for OP timing, stack overflow and reset during EXEC.
module tb_alu_issue;
  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_OP   = 2'd2;
  localparam logic [1:0] K_CLR  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_kind;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_use_carry;
  logic [31:0] alu_a, alu_b, alu_out, top;
  logic        alu_ic, alu_oc, alu_oo;
  logic [3:0]  alu_opcode;
  logic [3:0]  depth;
  logic        carry, overflow, err_underflow, err_overflow;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH_MAG(5), .DEPTH_MAG(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cmd_use_carry(cmd_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo),
    .top(top), .depth(depth), .carry(carry), .overflow(overflow),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  // Combinational ALU stand-in; non-ADD opcodes return flag values opposite to
  // the current ones so any leakage into the flags is visible.
  always_comb begin
    alu_out = '0;
    alu_oc  = ~carry;
    alu_oo  = ~overflow;
    case (alu_opcode)
      OP_ADD: begin
        {alu_oc, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_ic};
        alu_oo = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      OP_AND:  alu_out = alu_a & alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_LSL:  alu_out = alu_a << alu_b[4:0];
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [3:0]  opc;
    logic        uc;
    logic [31:0] e_top;
    logic [3:0]  e_depth;
    logic        e_c, e_o, e_eu, e_eo, e_ic;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one command; if it started an OP, let the EXEC cycle complete too.
  task automatic issue(input logic [1:0] k, input logic [31:0] d, input logic [3:0] opc,
                       input logic uc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = k; cmd_data = d; cmd_opcode = opc; cmd_use_carry = uc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!cmd_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " depth"}, 32'(depth), 32'd0);
    chk({tag, " top"}, top, 32'd0);
    chk({tag, " carry"}, 32'(carry), 32'd0);
    chk({tag, " ovf"}, 32'(overflow), 32'd0);
    chk({tag, " err_uf"}, 32'(err_underflow), 32'd0);
    chk({tag, " err_of"}, 32'(err_overflow), 32'd0);
    chk({tag, " alu_a"}, alu_a, 32'd0);
    chk({tag, " alu_b"}, alu_b, 32'd0);
    chk({tag, " alu_ic"}, 32'(alu_ic), 32'd0);
    chk({tag, " alu_opc"}, 32'(alu_opcode), 32'd0);
  endtask

  initial begin
    //             kind    data          opc     uc    top           dep  c  o eu eo ic
    vecs.push_back('{K_PUSH, 32'hFFFFFFFF, OP_ADD, 1'b0, 32'hFFFFFFFF, 4'd1, 0, 0, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h00000001, OP_ADD, 1'b0, 32'h00000001, 4'd2, 0, 0, 0, 0, 0});
    vecs.push_back('{K_OP,   32'h0,        OP_ADD, 1'b0, 32'h00000000, 4'd1, 1, 0, 0, 0, 0});
    vecs.push_back('{K_POP,  32'h0,        OP_ADD, 1'b0, 32'h00000000, 4'd0, 1, 0, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h7FFFFFFF, OP_ADD, 1'b0, 32'h7FFFFFFF, 4'd1, 1, 0, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h00000001, OP_ADD, 1'b0, 32'h00000001, 4'd2, 1, 0, 0, 0, 0});
    vecs.push_back('{K_OP,   32'h0,        OP_ADD, 1'b0, 32'h80000000, 4'd1, 0, 1, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h80000000, OP_ADD, 1'b0, 32'h80000000, 4'd2, 0, 1, 0, 0, 0});
    vecs.push_back('{K_OP,   32'h0,        OP_ADD, 1'b1, 32'h00000000, 4'd1, 1, 1, 0, 0, 0});
    vecs.push_back('{K_POP,  32'h0,        OP_ADD, 1'b0, 32'h00000000, 4'd0, 1, 1, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h00000003, OP_ADD, 1'b0, 32'h00000003, 4'd1, 1, 1, 0, 0, 0});
    vecs.push_back('{K_PUSH, 32'h00000004, OP_ADD, 1'b0, 32'h00000004, 4'd2, 1, 1, 0, 0, 0});
    vecs.push_back('{K_OP,   32'h0,        OP_LSL, 1'b1, 32'h00000030, 4'd1, 1, 1, 0, 0, 1});
    vecs.push_back('{K_PUSH, 32'h00000005, OP_ADD, 1'b0, 32'h00000005, 4'd2, 1, 1, 0, 0, 1});
    vecs.push_back('{K_OP,   32'h0,        OP_ADD, 1'b1, 32'h00000036, 4'd1, 0, 0, 0, 0, 1});
    vecs.push_back('{K_POP,  32'h0,        OP_ADD, 1'b0, 32'h00000000, 4'd0, 0, 0, 0, 0, 1});
    vecs.push_back('{K_POP,  32'h0,        OP_ADD, 1'b0, 32'h00000000, 4'd0, 0, 0, 1, 0, 1});
    vecs.push_back('{K_PUSH, 32'h00000005, OP_ADD, 1'b0, 32'h00000005, 4'd1, 0, 0, 1, 0, 1});
    vecs.push_back('{K_OP,   32'h0,        OP_AND, 1'b0, 32'h00000005, 4'd1, 0, 0, 1, 0, 1});
    vecs.push_back('{K_CLR,  32'h0,        OP_ADD, 1'b0, 32'h00000005, 4'd1, 0, 0, 0, 0, 1});
    vecs.push_back('{K_PUSH, 32'hA5A5A5A5, OP_ADD, 1'b0, 32'hA5A5A5A5, 4'd2, 0, 0, 0, 0, 1});
    vecs.push_back('{K_OP,   32'h0,        OP_XOR, 1'b0, 32'hA5A5A5A0, 4'd1, 0, 0, 0, 0, 0});

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_kind = K_PUSH; cmd_opcode = 4'h0;
    cmd_data = '0; cmd_use_carry = 1'b0;
    #1;
    chk_reset_outputs("rst");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].kind, vecs[i].data, vecs[i].opc, vecs[i].uc);
      chk($sformatf("v%0d top", i), top, vecs[i].e_top);
      chk($sformatf("v%0d depth", i), 32'(depth), 32'(vecs[i].e_depth));
      chk($sformatf("v%0d carry", i), 32'(carry), 32'(vecs[i].e_c));
      chk($sformatf("v%0d ovf", i), 32'(overflow), 32'(vecs[i].e_o));
      chk($sformatf("v%0d err_uf", i), 32'(err_underflow), 32'(vecs[i].e_eu));
      chk($sformatf("v%0d err_of", i), 32'(err_overflow), 32'(vecs[i].e_eo));
      chk($sformatf("v%0d alu_ic", i), 32'(alu_ic), 32'(vecs[i].e_ic));
    end

    // OP timing: ready drops for exactly the EXEC cycle; a held command is not taken.
    issue(K_POP, 32'h0, OP_ADD, 1'b0);
    issue(K_PUSH, 32'hFFFFFFFF, OP_ADD, 1'b0);
    issue(K_PUSH, 32'h00000001, OP_ADD, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = K_OP; cmd_opcode = OP_ADD; cmd_use_carry = 1'b0;
    #4; chk("op pre ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("exec ready", 32'(cmd_ready), 32'd0);
    chk("exec alu_a", alu_a, 32'hFFFFFFFF);
    chk("exec alu_b", alu_b, 32'h00000001);
    chk("exec alu_opc", 32'(alu_opcode), 32'(OP_ADD));
    chk("exec depth", 32'(depth), 32'd2);
    @(negedge clk);
    cmd_kind = K_PUSH; cmd_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("post ready", 32'(cmd_ready), 32'd1);
    chk("post top", top, 32'h00000000);
    chk("post depth", 32'(depth), 32'd1);
    chk("post carry", 32'(carry), 32'd1);
    chk("post ovf", 32'(overflow), 32'd0);
    cmd_valid = 1'b0;

    // Fill past capacity.
    issue(K_POP, 32'h0, OP_ADD, 1'b0);
    for (int v = 1; v <= 9; v++) issue(K_PUSH, 32'(v), OP_ADD, 1'b0);
    chk("full depth", 32'(depth), 32'd8);
    chk("full top", top, 32'd8);
    chk("full err_of", 32'(err_overflow), 32'd1);
    chk("full err_uf", 32'(err_underflow), 32'd0);
    issue(K_POP, 32'h0, OP_ADD, 1'b0);
    chk("pop top", top, 32'd7);
    chk("pop depth", 32'(depth), 32'd7);

    // Asynchronous reset in the middle of EXEC.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = K_OP; cmd_opcode = OP_XOR; cmd_use_carry = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("xor exec ready", 32'(cmd_ready), 32'd0);
    chk("xor exec alu_a", alu_a, 32'd6);
    chk("xor exec alu_b", alu_b, 32'd7);
    chk("xor exec alu_ic", 32'(alu_ic), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel ready", 32'(cmd_ready), 32'd1);
    chk("rel depth", 32'(depth), 32'd0);
    chk("rel top", top, 32'd0);
    issue(K_PUSH, 32'h11, OP_ADD, 1'b0);
    issue(K_PUSH, 32'h22, OP_ADD, 1'b0);
    chk("rel push top", top, 32'h22);
    chk("rel push depth", 32'(depth), 32'd2);
    issue(K_POP, 32'h0, OP_ADD, 1'b0);
    chk("rel pop top", top, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
